// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal view controller.
//   - Q2.13 coordinate format constants and the internal arithmetic width.
//   - Screen geometry used for the centre-preserving zoom offsets.
//   - Button indices, command encoding, FSM state encoding, view record.
//   - sat16(): clamps a 20-bit signed result into the 16-bit coordinate range.
package fractal_pkg;

  localparam int FRAC_BITS = 13;
  localparam int COORD_W   = 16;
  localparam int CALC_W    = 20;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int H_HALF    = H_RES / 2;   // 320: zoom-out x offset in steps
  localparam int V_HALF    = V_RES / 2;   // 240: zoom-out y offset in steps
  localparam int H_QUARTER = H_RES / 4;   // 160: zoom-in x offset in steps
  localparam int V_QUARTER = V_RES / 4;   // 120: zoom-in y offset in steps

  // Bit positions of the conditioned buttons; higher index wins on a tie.
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_ZOUT  = 4;
  localparam int BTN_ZIN   = 5;
  localparam int BTN_N     = 6;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_ZIN, CMD_ZOUT, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT
  } cmd_e;

  typedef enum logic [1:0] {
    ST_RESTART, ST_RENDER, ST_IDLE, ST_UPDATE
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    logic [COORD_W-1:0] step_x;
    logic [COORD_W-1:0] step_y;
  } view_t;

  // In range when every bit above the 16-bit sign bit matches it.
  function automatic logic [COORD_W-1:0] sat16(input logic signed [CALC_W-1:0] v);
    if (v[CALC_W-1:COORD_W-1] == '0 || v[CALC_W-1:COORD_W-1] == '1)
      return v[COORD_W-1:0];
    else if (v[CALC_W-1])
      return {1'b1, {(COORD_W-1){1'b0}}};
    else
      return {1'b0, {(COORD_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/fractal_view_ctrl_if.sv
// Board-side bundle of the view controller.
//   master: drives raw buttons and frame_done, observes the view window.
//   slave : the controller; reads buttons/frame_done, drives
//           startX/startY/stepX/stepY, restart and busy.
interface fractal_view_ctrl_if;
  import fractal_pkg::*;

  logic               btn_up, btn_down, btn_left, btn_right;
  logic               btn_zin, btn_zout;
  logic               frame_done;
  logic [COORD_W-1:0] startX, startY;
  logic [COORD_W-1:0] stepX, stepY;
  logic               restart;
  logic               busy;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_zin, btn_zout, frame_done,
    input  startX, startY, stepX, stepY, restart, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_zin, btn_zout, frame_done,
    output startX, startY, stepX, stepY, restart, busy
  );
endinterface

// File: rtl/fractal_view_ctrl_btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce, rising-edge pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_btn      : raw asynchronous button level
//   o_cmd      : one-cycle pulse when a debounced 0->1 transition is accepted
// A new level is accepted after DEBOUNCE_CYCLES consecutive cycles that differ
// from the accepted level; any return to the accepted level restarts the count.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_cmd
);
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2, r_stable, r_cmd;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_cmd    <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_cmd   <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_cmd    <= r_sync2;          // pulse only on the press, not the release
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cmd = r_cmd;
endmodule

// File: rtl/fractal_view_ctrl.sv
// Pan/zoom controller in front of the fractal engine.
//   Clk_100M : system clock
//   reset    : asynchronous active-low reset
//   bus      : slave side of fractal_view_ctrl_if (buttons, frame_done in;
//              startX/startY/stepX/stepY, restart, busy out)
// Commands are accepted only in IDLE (after the engine reports frame done),
// applied in UPDATE, then the engine is restarted for one cycle.
module fractal_view_ctrl
  import fractal_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 1_000_000,
  parameter int                 PAN_SHIFT       = 5,
  parameter logic [COORD_W-1:0] START_X_INIT    = 16'hE000,
  parameter logic [COORD_W-1:0] START_Y_INIT    = 16'hE000,
  parameter logic [COORD_W-1:0] STEP_X_INIT     = 16'h0019,
  parameter logic [COORD_W-1:0] STEP_Y_INIT     = 16'h0022,
  parameter logic [COORD_W-1:0] MAX_STEP        = 16'h0200
) (
  input logic                Clk_100M,
  input logic                reset,
  fractal_view_ctrl_if.slave bus
);
  localparam view_t VIEW_INIT = '{start_x: START_X_INIT, start_y: START_Y_INIT,
                                  step_x:  STEP_X_INIT,  step_y:  STEP_Y_INIT};

  logic [BTN_N-1:0] w_btn_raw, w_pulse;
  cmd_e             w_cmd_sel, r_cmd;
  state_e           r_state, w_next;
  view_t            r_view, w_view_next;
  logic             r_run, r_render_first;

  assign w_btn_raw = {bus.btn_zin, bus.btn_zout, bus.btn_up,
                      bus.btn_down, bus.btn_left, bus.btn_right};

  for (genvar g = 0; g < BTN_N; g++) begin : g_btn
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clk   (Clk_100M),
      .rst_n (reset),
      .i_btn (w_btn_raw[g]),
      .o_cmd (w_pulse[g])
    );
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_cmd_sel = CMD_NONE;
    if      (w_pulse[BTN_ZIN])   w_cmd_sel = CMD_ZIN;
    else if (w_pulse[BTN_ZOUT])  w_cmd_sel = CMD_ZOUT;
    else if (w_pulse[BTN_UP])    w_cmd_sel = CMD_UP;
    else if (w_pulse[BTN_DOWN])  w_cmd_sel = CMD_DOWN;
    else if (w_pulse[BTN_LEFT])  w_cmd_sel = CMD_LEFT;
    else if (w_pulse[BTN_RIGHT]) w_cmd_sel = CMD_RIGHT;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk_100M or negedge reset) begin
    if (!reset) r_state <= ST_RESTART;
    else        r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RESTART: if (r_run) w_next = ST_RENDER;  // first cycle out of reset holds here
      ST_RENDER:  if (bus.frame_done && !r_render_first) w_next = ST_IDLE;
      ST_IDLE:    if (|w_pulse) w_next = ST_UPDATE;
      ST_UPDATE:  w_next = ST_RESTART;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // r_run keeps restart low while reset is asserted even though the state
  // register already sits in RESTART.
  always_comb begin
    bus.restart = (r_state == ST_RESTART) && r_run;
    bus.busy    = (r_state != ST_IDLE);
  end

  // ---------------- datapath ----------------
  logic signed [CALC_W-1:0] w_sx, w_sy, w_stx, w_sty;
  logic signed [CALC_W-1:0] w_pan_x, w_pan_y, w_zin_x, w_zin_y, w_zout_x, w_zout_y;
  logic                     w_zin_blocked, w_zout_blocked;

  always_comb begin
    w_sx  = {{(CALC_W-COORD_W){r_view.start_x[COORD_W-1]}}, r_view.start_x};
    w_sy  = {{(CALC_W-COORD_W){r_view.start_y[COORD_W-1]}}, r_view.start_y};
    w_stx = {{(CALC_W-COORD_W){1'b0}}, r_view.step_x};
    w_sty = {{(CALC_W-COORD_W){1'b0}}, r_view.step_y};
    w_pan_x  = w_stx << PAN_SHIFT;
    w_pan_y  = w_sty << PAN_SHIFT;
    // Centre-preserving offsets: H_QUARTER/V_QUARTER steps in, H_HALF/V_HALF out.
    w_zin_x  = (w_stx << 7) + (w_stx << 5);   // *160
    w_zin_y  = (w_sty << 7) - (w_sty << 3);   // *120
    w_zout_x = (w_stx << 8) + (w_stx << 6);   // *320
    w_zout_y = (w_sty << 8) - (w_sty << 4);   // *240
    w_zin_blocked  = (r_view.step_x <= COORD_W'(1)) || (r_view.step_y <= COORD_W'(1));
    w_zout_blocked = ({r_view.step_x, 1'b0} > {1'b0, MAX_STEP}) ||
                     ({r_view.step_y, 1'b0} > {1'b0, MAX_STEP});
  end

  always_comb begin
    w_view_next = r_view;
    case (r_cmd)
      CMD_UP:    w_view_next.start_y = sat16(w_sy - w_pan_y);
      CMD_DOWN:  w_view_next.start_y = sat16(w_sy + w_pan_y);
      CMD_LEFT:  w_view_next.start_x = sat16(w_sx - w_pan_x);
      CMD_RIGHT: w_view_next.start_x = sat16(w_sx + w_pan_x);
      CMD_ZIN: if (!w_zin_blocked) begin
        w_view_next.start_x = sat16(w_sx + w_zin_x);
        w_view_next.start_y = sat16(w_sy + w_zin_y);
        w_view_next.step_x  = r_view.step_x >> 1;
        w_view_next.step_y  = r_view.step_y >> 1;
      end
      CMD_ZOUT: if (!w_zout_blocked) begin
        w_view_next.start_x = sat16(w_sx - w_zout_x);
        w_view_next.start_y = sat16(w_sy - w_zout_y);
        w_view_next.step_x  = r_view.step_x << 1;
        w_view_next.step_y  = r_view.step_y << 1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk_100M or negedge reset) begin
    if (!reset) begin
      r_run          <= 1'b0;
      r_render_first <= 1'b0;
      r_cmd          <= CMD_NONE;
      r_view         <= VIEW_INIT;
    end else begin
      r_run          <= 1'b1;
      r_render_first <= (r_state == ST_RESTART);   // masks frame_done for one cycle
      if (r_state == ST_IDLE && |w_pulse) r_cmd  <= w_cmd_sel;
      if (r_state == ST_UPDATE)           r_view <= w_view_next;
    end
  end

  assign bus.startX = r_view.start_x;
  assign bus.startY = r_view.start_y;
  assign bus.stepX  = r_view.step_x;
  assign bus.stepY  = r_view.step_y;
endmodule

// File: tb/tb_fractal_view_ctrl.sv
// Directed bench for fractal_view_ctrl with DEBOUNCE_CYCLES=4.
// A button held from just before posedge 1 yields cmd after edge 6,
// UPDATE after edge 7 and restart after edge 8.
module tb_fractal_view_ctrl;
  localparam logic [5:0] M_RIGHT = 6'b000001;
  localparam logic [5:0] M_LEFT  = 6'b000010;
  localparam logic [5:0] M_DOWN  = 6'b000100;
  localparam logic [5:0] M_UP    = 6'b001000;
  localparam logic [5:0] M_ZOUT  = 6'b010000;
  localparam logic [5:0] M_ZIN   = 6'b100000;
  localparam logic [63:0] V_INIT = {16'hE000, 16'hE000, 16'h0019, 16'h0022};

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fractal_view_ctrl_if bus();

  fractal_view_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk_100M (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_btns(input logic [5:0] m);
    {bus.btn_zin, bus.btn_zout, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = m;
  endtask

  function automatic logic [63:0] view();
    return {bus.startX, bus.startY, bus.stepX, bus.stepY};
  endfunction

  // Hold mask for 'hold' cycles, observe 14 cycles, report restart activity.
  task automatic do_cmd(input logic [5:0] mask, input int hold,
                        output int n_rst, output int first_at);
    n_rst = 0;
    first_at = -1;
    set_btns(mask);
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == hold) set_btns('0);
      if (bus.restart === 1'b1) begin
        n_rst++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.busy !== 1'b0 && k < 40) begin
      tick();
      k++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_timeout: busy=%b want 0", tag, bus.busy);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    set_btns('0);
    bus.frame_done = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    wait_idle("apply_reset");
  endtask

  task automatic cmp_view(input string tag, input logic [63:0] want);
    n_cmp++;
    if (view() !== want) begin
      n_bad++;
      $display("FAIL %s view: got %h want %h", tag, view(), want);
    end
  endtask

  task automatic cmp_int(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    set_btns('0);
    bus.frame_done = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    cmp_view("reset_state", V_INIT);
    n_cmp++;
    if ({bus.restart, bus.busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_ctrl restart/busy: got %b want 01", {bus.restart, bus.busy});
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.restart !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_restart_pulse: got %b want 1", bus.restart);
    end
    tick();
    n_cmp++;
    if ({bus.restart, bus.busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_render restart/busy: got %b want 01", {bus.restart, bus.busy});
    end
    repeat (4) tick();
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL render_wait busy: got %b want 1", bus.busy);
    end
    bus.frame_done = 1'b1;
    wait_idle("reset_to_idle");
  endtask

  task automatic test_zoom_in();
    int n, first;
    do_cmd(M_ZIN, 6, n, first);
    cmp_int("zin_restart_count", n, 1);
    cmp_int("zin_restart_cycle", first, 8);
    cmp_view("zin", {16'hEFA0, 16'hEFF0, 16'h000C, 16'h0011});
    wait_idle("zin");
  endtask

  task automatic test_pan();
    int n, first;
    apply_reset();
    do_cmd(M_RIGHT, 6, n, first);
    cmp_view("pan_right", {16'hE320, 16'hE000, 16'h0019, 16'h0022});
    wait_idle("pan_right");
    do_cmd(M_UP, 6, n, first);
    cmp_view("pan_up", {16'hE320, 16'hDBC0, 16'h0019, 16'h0022});
    wait_idle("pan_up");
  endtask

  task automatic test_zoom_out();
    int n, first;
    apply_reset();
    do_cmd(M_ZOUT, 6, n, first);
    cmp_view("zout1", {16'hC0C0, 16'hC020, 16'h0032, 16'h0044});
    wait_idle("zout1");
    do_cmd(M_ZOUT, 6, n, first);
    cmp_view("zout2", {16'h8240, 16'h8060, 16'h0064, 16'h0088});
    wait_idle("zout2");
    do_cmd(M_ZOUT, 6, n, first);
    cmp_view("zout3_sat", {16'h8000, 16'h8000, 16'h00C8, 16'h0110});
    wait_idle("zout3");
    do_cmd(M_ZOUT, 6, n, first);
    cmp_view("zout_limit_hold", {16'h8000, 16'h8000, 16'h00C8, 16'h0110});
    cmp_int("zout_limit_restart", first, 8);
    wait_idle("zout4");
    do_cmd(M_RIGHT, 6, n, first);
    cmp_view("wide_right", {16'h9900, 16'h8000, 16'h00C8, 16'h0110});
    wait_idle("wide_right");
    do_cmd(M_LEFT, 6, n, first);
    cmp_view("left_to_min", {16'h8000, 16'h8000, 16'h00C8, 16'h0110});
    wait_idle("left1");
    do_cmd(M_LEFT, 6, n, first);
    cmp_view("left_saturate", {16'h8000, 16'h8000, 16'h00C8, 16'h0110});
    wait_idle("left2");
  endtask

  task automatic test_render_drop();
    int n, first;
    apply_reset();
    bus.frame_done = 1'b0;
    do_cmd(M_DOWN, 6, n, first);
    cmp_int("down_restart_count", n, 1);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL render_hold busy: got %b want 1", bus.busy);
    end
    do_cmd(M_LEFT, 6, n, first);
    cmp_int("render_left_restart", n, 0);
    cmp_view("render_left_dropped", {16'hE000, 16'hE440, 16'h0019, 16'h0022});
    bus.frame_done = 1'b1;
    wait_idle("render_release");
    n = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.restart === 1'b1) n++;
    end
    cmp_int("render_not_queued", n, 0);
  endtask

  task automatic test_glitch();
    int n, first;
    do_cmd(M_DOWN, 3, n, first);
    cmp_int("glitch_restart", n, 0);
    cmp_view("glitch_view", {16'hE000, 16'hE440, 16'h0019, 16'h0022});
  endtask

  task automatic test_priority();
    int n, first;
    apply_reset();
    do_cmd(M_ZIN | M_LEFT, 6, n, first);
    cmp_int("prio_restart_count", n, 1);
    cmp_view("prio_zin_wins", {16'hEFA0, 16'hEFF0, 16'h000C, 16'h0011});
    wait_idle("prio");
    n = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.restart === 1'b1) n++;
    end
    cmp_int("prio_left_dropped", n, 0);
  endtask

  task automatic test_reset_in_update();
    int  n, first;
    bit  found = 0;
    apply_reset();
    do_cmd(M_RIGHT, 6, n, first);
    cmp_view("pre_update_right", {16'hE320, 16'hE000, 16'h0019, 16'h0022});
    wait_idle("pre_update");
    set_btns(M_ZIN);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) set_btns('0);
      if (bus.busy === 1'b1) begin
        found = 1;
        break;
      end
    end
    cmp_int("update_reached", int'(found), 1);
    set_btns('0);
    reset = 1'b0;
    #1;
    cmp_view("async_reset_view", V_INIT);
    n_cmp++;
    if ({bus.restart, bus.busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL async_reset restart/busy: got %b want 01", {bus.restart, bus.busy});
    end
    @(negedge clk);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.restart !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_restart: got %b want 1", bus.restart);
    end
    wait_idle("post_reset");
    cmp_view("post_reset_view", V_INIT);
  endtask

  initial begin
    test_reset();
    test_zoom_in();
    test_pan();
    test_zoom_out();
    test_render_drop();
    test_glitch();
    test_priority();
    test_reset_in_update();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
